// File: rtl/led_pkg.sv
//------------------------------------------------------------------------------
// Module : led_pkg
// Brief  : Shared mode encoding for the LED PWM array.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package led_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    LED_OFF     = 2'd0,
    LED_STATIC  = 2'd1,
    LED_BREATHE = 2'd2,
    LED_BLINK   = 2'd3
  } led_mode_e;

endpackage

`default_nettype wire

// File: rtl/led_pwm_array_if.sv
//------------------------------------------------------------------------------
// Module : led_pwm_array_if
// Brief  : Channel configuration bus (write strobe, channel, mode, duty).
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface led_pwm_array_if
  import led_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int PWM_W = 8
) ();

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic             cfg_we;
  logic [CH_W-1:0]  cfg_ch;
  led_mode_e        cfg_mode;
  logic [PWM_W-1:0] cfg_duty;

  modport master (output cfg_we, cfg_ch, cfg_mode, cfg_duty);
  modport slave  (input  cfg_we, cfg_ch, cfg_mode, cfg_duty);

endinterface

`default_nettype wire

// File: rtl/led_sd_pwm.sv
//------------------------------------------------------------------------------
// Module : led_sd_pwm
// Brief  : First-order sigma-delta modulator; output is the registered carry.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module led_sd_pwm #(
  parameter int PWM_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PWM_W-1:0] intensity,
  output logic             pwm_out
);

  logic [PWM_W-1:0] r_acc;
  logic [PWM_W:0]   w_sum;

  assign w_sum = {1'b0, r_acc} + {1'b0, intensity};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      pwm_out <= 1'b0;
    end else begin
      r_acc   <= w_sum[PWM_W-1:0];
      pwm_out <= w_sum[PWM_W];
    end
  end

endmodule

`default_nettype wire

// File: rtl/led_pwm_array.sv
//------------------------------------------------------------------------------
// Module : led_pwm_array
// Brief  : Multi-channel LED driver (OFF/STATIC/BREATHE/BLINK) with shared
//          time-base. Define LED_GAMMA_EN for square-law intensity gamma.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module led_pwm_array
  import led_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int PWM_W    = 8,
  parameter int TICK_DIV = 65536,
  parameter int BLINK_T  = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  led_pwm_array_if.slave  cfg,
  output logic [N_CH-1:0] led
);

  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int PRE_W = $clog2(TICK_DIV);
  localparam int BLK_W = (BLINK_T > 1) ? $clog2(BLINK_T) : 1;

  logic [PRE_W-1:0] r_presc;
  logic [PWM_W:0]   r_ramp;
  logic [BLK_W-1:0] r_blink_cnt;
  logic             r_blink_ph;
  logic             w_tick;
  logic [PWM_W-1:0] w_tri;
  logic             w_ch_ok;

  assign w_tick = (r_presc == PRE_W'(TICK_DIV - 1));
  assign w_tri  = r_ramp[PWM_W] ? r_ramp[PWM_W-1:0] : ~r_ramp[PWM_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc     <= '0;
      r_ramp      <= '0;
      r_blink_cnt <= '0;
      r_blink_ph  <= 1'b0;
    end else if (w_tick) begin
      r_presc <= '0;
      r_ramp  <= r_ramp + (PWM_W+1)'(1);
      if (r_blink_cnt == BLK_W'(BLINK_T - 1)) begin
        r_blink_cnt <= '0;
        r_blink_ph  <= ~r_blink_ph;
      end else begin
        r_blink_cnt <= r_blink_cnt + BLK_W'(1);
      end
    end else begin
      r_presc <= r_presc + PRE_W'(1);
    end
  end

  // A power-of-two channel count makes every cfg_ch encoding valid.
  if (N_CH == (1 << CH_W)) begin : g_ch_full
    assign w_ch_ok = 1'b1;
  end else begin : g_ch_part
    assign w_ch_ok = (cfg.cfg_ch < CH_W'(N_CH));
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    led_mode_e        r_mode;
    logic [PWM_W-1:0] r_duty;
    logic [PWM_W-1:0] w_lin;
    logic [PWM_W-1:0] w_int;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_mode <= LED_OFF;
        r_duty <= '0;
      end else if (cfg.cfg_we && w_ch_ok && (cfg.cfg_ch == CH_W'(i))) begin
        r_mode <= cfg.cfg_mode;
        r_duty <= cfg.cfg_duty;
      end
    end

    always_comb begin
      w_lin = '0;
      case (r_mode)
        LED_STATIC:  w_lin = r_duty;
        LED_BREATHE: w_lin = w_tri;
        LED_BLINK:   w_lin = r_blink_ph ? r_duty : '0;
        default:     w_lin = '0;
      endcase
    end

`ifdef LED_GAMMA_EN
    localparam int SQ_W = 2 * PWM_W;
    assign w_int = PWM_W'((SQ_W'(w_lin) * SQ_W'(w_lin)) >> PWM_W);
`else
    assign w_int = w_lin;
`endif

    led_sd_pwm #(.PWM_W(PWM_W)) u_pwm (
      .clk       (clk),
      .rst_n     (rst_n),
      .intensity (w_int),
      .pwm_out   (led[i])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_led_pwm_array.sv
//------------------------------------------------------------------------------
// Module : tb_led_pwm_array
// Brief  : Directed, table-driven self-checking bench for led_pwm_array.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_led_pwm_array;
  import led_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] led;
  int         n_cmp = 0;
  int         n_err = 0;

  led_pwm_array_if #(.N_CH(4), .PWM_W(8)) u_if ();

  led_pwm_array #(.N_CH(4), .PWM_W(8), .TICK_DIV(4), .BLINK_T(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cfg   (u_if),
    .led   (led)
  );

  always #5 clk = ~clk;

  typedef struct {
    int        ch;
    led_mode_e mode;
    int        duty;
    int        exp_hi;
  } vec_t;

  vec_t vecs[7];

  function automatic int gam(int d);
`ifdef LED_GAMMA_EN
    return (d * d) >> 8;
`else
    return d;
`endif
  endfunction

  function automatic int tri_of(int r);
    int rr;
    rr = r % 512;
    return (rr >= 256) ? rr - 256 : 255 - rr;
  endfunction

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_rng(string name, int act, int lo, int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Called at a negedge: drive now, the write lands on the next posedge.
  task automatic write(int ch, led_mode_e m, int d);
    u_if.cfg_we   = 1'b1;
    u_if.cfg_ch   = 2'(ch);
    u_if.cfg_mode = m;
    u_if.cfg_duty = 8'(d);
    @(negedge clk);
    u_if.cfg_we   = 1'b0;
  endtask

  task automatic count_hi(int b, int n, output int c);
    c = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (led[b]) c++;
    end
  endtask

  task automatic reset_and_write(int ch, led_mode_e m, int d);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    write(ch, m, d);
  endtask

  initial begin
    int c;
    int s;
    int blk_exp[7];

    vecs[0] = '{0, LED_STATIC, 128, gam(128)};
    vecs[1] = '{0, LED_STATIC, 0,   gam(0)};
    vecs[2] = '{0, LED_STATIC, 255, gam(255)};
    vecs[3] = '{3, LED_STATIC, 1,   gam(1)};
    vecs[4] = '{3, LED_STATIC, 64,  gam(64)};
    vecs[5] = '{0, LED_OFF,    200, 0};
    vecs[6] = '{3, LED_STATIC, 16,  gam(16)};
    blk_exp = '{0, 7, 0, 8, 0, 8, 0};

    rst_n         = 1'b0;
    u_if.cfg_we   = 1'b0;
    u_if.cfg_ch   = '0;
    u_if.cfg_mode = LED_OFF;
    u_if.cfg_duty = '0;
    repeat (3) @(negedge clk);
    check("reset_led", int'(led), 0);
    rst_n = 1'b1;
    count_hi(0, 16, c);
    check("idle_after_reset", c, 0);

    for (int i = 0; i < 7; i++) begin
      write(vecs[i].ch, vecs[i].mode, vecs[i].duty);
      count_hi(vecs[i].ch, 256, c);
      check($sformatf("static_vec%0d", i), c, vecs[i].exp_hi);
    end

    // Blink: phase turns on at edge t0+8 and toggles every 8 edges.
    reset_and_write(2, LED_BLINK, 255);
    count_hi(2, 7, c);
    check("blink_pre", c, blk_exp[0]);
    for (int j = 1; j < 7; j++) begin
      count_hi(2, 8, c);
      check($sformatf("blink_blk%0d", j), c, blk_exp[j]);
    end

    // Breathe: ramp value at edge t0+d is d/4; one sigma-delta window bound.
    reset_and_write(1, LED_BREATHE, 0);
    for (int w = 0; w < 8; w++) begin
      s = 0;
      for (int d = 1 + 256 * w; d <= 256 + 256 * w; d++) s += gam(tri_of(d / 4));
      count_hi(1, 256, c);
      check_rng($sformatf("breathe_win%0d", w), c, s / 256, (s + 255) / 256);
    end

    // Mode change keeps the accumulator: held residue yields an immediate carry.
    reset_and_write(0, LED_STATIC, 255);
    repeat (5) @(negedge clk);
    write(0, LED_OFF, 0);
    count_hi(0, 10, c);
    check("off_no_pulse", c, 0);
    write(0, LED_STATIC, 255);
    check("modechg_first", int'(led[0]), 0);
    @(negedge clk);
    check("modechg_acc_kept", int'(led[0]), 1);

    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check("async_reset_led", int'(led), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    c = 0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (led != 4'b0) c++;
    end
    check("off_after_midrun_reset", c, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
